exec_stage: RTL and testbench
=============================

# exec_stage

Execute-stage wrapper around the combinational ALU. It accepts one 16-bit instruction per cycle over a valid/ready handshake and reads operands from an internal 8×16 register file. It presents operands and control to the ALU, then writes the ALU result back one cycle later. Operands are forwarded from the in-flight instruction, and a HALT/resume state machine stops instruction intake.

## Interface
- NREGS, 8, register count; index width is log2(NREGS)=3
- DATA_W, 16, datapath width; must match the ALU operand width
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- instr_valid  in  1  upstream has an instruction on instr
- instr_ready  out  1  block accepts instr this cycle
- instr  in  16  [15:13] op, [12:10] rd, [9:7] rs1, [6:4] rs2, [9:0] imm10 (LDI only)
- resume  in  1  single-cycle pulse; leaves HALTED
- alu_a  out  16  operand A, registered
- alu_b  out  16  operand B, registered
- alu_ctrl  out  3  op field of the EX instruction, registered
- alu_result  in  16  combinational ALU output for alu_a/alu_b/alu_ctrl
- wb_valid  out  1  a register write occurred at the last edge
- wb_rd  out  3  destination of that write
- wb_data  out  16  value written
- halted  out  1  state == HALTED
- dbg_addr  in  3  debug read index
- dbg_data  out  16  combinational read of regfile[dbg_addr]

## Operation
- Opcodes 000–101 are the ALU ops ADD, SUB, AND, OR, XOR, NOR: rd ← ALU(rs1, rs2).
- Opcode 110 is LDI: rd ← {6'b0, imm10}. The ALU is bypassed.
- Opcode 111 is HALT: no write.
- Handshake: a transfer occurs when instr_valid && instr_ready.
  - instr_ready = (state==RUN) && !(ex_valid && ex_op==HALT).
  - instr must be held stable while valid && !ready. Unaccepted instructions are never consumed.
- EX register holds ex_valid, ex_op, ex_rd, ex_imm and alu_a/alu_b/alu_ctrl. It loads on transfer; otherwise ex_valid clears at the next edge.
- Operand read at accept: the source is regfile[rs], except in two cases.
  - If ex_valid, ex_rd==rs, rs!=0 and ex_op≠HALT, the source is the forwarded EX value: alu_result, or the zero-extended imm for LDI.
  - r0 always reads 0. Writes to r0 are dropped (wb_valid still pulses with wb_rd=0 and wb_data=value).
- Writeback: at the edge after EX holds a valid non-HALT op, the block writes regfile[ex_rd], sets wb_valid=1, and sets wb_rd/wb_data. Otherwise wb_valid=0.
- State machine:
  - RUN → HALTED at the edge where EX holds a valid HALT.
  - HALTED → RUN at the edge where resume=1.
  - resume in RUN is ignored.
- Arithmetic: ALU results wrap modulo 2^16. The block passes them through unmodified; no flags.

## Timing
- Reset values:
  - regfile all 0; state RUN; ex_valid 0.
  - alu_a, alu_b and alu_ctrl are 0; wb_valid, wb_rd and wb_data are 0; halted 0.
  - instr_ready=1 immediately after rst_n deasserts.
- Latency: accept at edge N → operands on alu_* after N → regfile write and wb_valid at edge N+1.
- Throughput: 1 instruction/cycle in RUN, including back-to-back dependent instructions via forwarding.
- Writeback and accept in the same cycle, same register: forwarding takes priority, so the new value is read and the stale value is not.
- HALT throughput:
  - After HALT is accepted at edge N, instr_ready=0 from N onward. No instruction is accepted behind HALT.
  - halted=1 from edge N+1.
- Resume: resume at edge M → state RUN and instr_ready=1 after M. An instruction held valid is accepted at edge M+1.
- Reset mid-operation discards the EX instruction (no write) and clears the HALTED state.
- dbg_data reflects a write in the cycle after the write edge.

## Structure
- Shared package risc_pkg:
  - opcode constants OP_ADD..OP_NOR, OP_LDI, OP_HALT;
  - instruction field positions;
  - DATA_W and REG_IDX_W;
  - state enum {RUN, HALTED}.
- Sub-module reg_file: NREGS×DATA_W storage with two combinational read ports, one debug read port and one write port, and r0 hardwired to zero. Async reset clears all entries.
- The ALU is instantiated alongside the block by the parent, not inside it.

## Test plan
- Reset then LDI r1,5; LDI r2,3; ADD r3,r1,r2 back-to-back → wb sequence (1,5),(2,3),(3,8); dbg_addr=3 → 8.
- Forwarding chain: LDI r1,0x3FF; SUB r2,r1,r1; NOR r3,r2,r0 → r2=0, r3=0xFFFF with no stall cycles.
- Wrap: LDI r1,1; NOR r2,r0,r0 (0xFFFF); ADD r3,r2,r1 → r3=0x0000.
- HALT with next instr_valid held:
  - ready low from accept, halted=1 one edge later, following instruction not accepted for 5 cycles;
  - resume pulse → accepted next edge.
- Write to r0: LDI r0,7 → wb_valid=1, wb_rd=0, wb_data=7; a following ADD r1,r0,r0 → r1=0.
- rst_n low while ADD is in EX → no write; after reset all regs read 0, halted=0, instr_ready=1.

Source files
------------

// File: rtl/risc_pkg.sv
// risc_pkg: shared opcodes, instruction field positions, widths and FSM states
package risc_pkg;
  localparam int NREGS = 8;
  localparam int DATA_W = 16;
  localparam int REG_IDX_W = $clog2(NREGS);
  localparam int IMM_W = 10;
  localparam int OP_LSB = 13;
  localparam int RD_LSB = 10;
  localparam int RS1_LSB = 7;
  localparam int RS2_LSB = 4;
  typedef logic [2:0] op_t;
  localparam op_t OP_ADD  = 3'd0;
  localparam op_t OP_SUB  = 3'd1;
  localparam op_t OP_AND  = 3'd2;
  localparam op_t OP_OR   = 3'd3;
  localparam op_t OP_XOR  = 3'd4;
  localparam op_t OP_NOR  = 3'd5;
  localparam op_t OP_LDI  = 3'd6;
  localparam op_t OP_HALT = 3'd7;
  typedef enum logic {RUN, HALTED} state_t;
endpackage

// File: rtl/exec_stage_if.sv
// exec_stage_if: instruction valid/ready handshake
interface exec_stage_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  modport master (output instr_valid, output instr, input instr_ready);
  modport slave (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/reg_file.sv
// reg_file: 2R+debug-read/1W register file, r0 never written so it always reads 0
module reg_file
  import risc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] waddr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic [REG_IDX_W-1:0] ra1,
  output logic [DATA_W-1:0]    rd1,
  input  logic [REG_IDX_W-1:0] ra2,
  output logic [DATA_W-1:0]    rd2,
  input  logic [REG_IDX_W-1:0] dbg_addr,
  output logic [DATA_W-1:0]    dbg_data
);
  logic [DATA_W-1:0] mem [NREGS];
  assign rd1 = mem[ra1];
  assign rd2 = mem[ra2];
  assign dbg_data = mem[dbg_addr];
  // clear on reset; writes to r0 are dropped
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    else if (we && waddr != '0) mem[waddr] <= wdata;
endmodule

// File: rtl/exec_stage.sv
// exec_stage: execute stage with forwarding, writeback and HALT/resume control
module exec_stage
  import risc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  exec_stage_if.slave          in_if,
  input  logic                 resume,
  output logic [DATA_W-1:0]    alu_a,
  output logic [DATA_W-1:0]    alu_b,
  output op_t                  alu_ctrl,
  input  logic [DATA_W-1:0]    alu_result,
  output logic                 wb_valid,
  output logic [REG_IDX_W-1:0] wb_rd,
  output logic [DATA_W-1:0]    wb_data,
  output logic                 halted,
  input  logic [REG_IDX_W-1:0] dbg_addr,
  output logic [DATA_W-1:0]    dbg_data
);
  op_t                  op, ex_op;
  logic [REG_IDX_W-1:0] rd, rs1, rs2, ex_rd;
  logic [IMM_W-1:0]     ex_imm;
  logic [DATA_W-1:0]    rf_a, rf_b, fwd_a, fwd_b, ex_val;
  logic                 ex_valid, ex_halt, wr, xfer;
  state_t               state, state_nxt;
  assign op = op_t'(in_if.instr[OP_LSB +: 3]);
  assign rd = in_if.instr[RD_LSB +: REG_IDX_W];
  assign rs1 = in_if.instr[RS1_LSB +: REG_IDX_W];
  assign rs2 = in_if.instr[RS2_LSB +: REG_IDX_W];
  assign ex_halt = ex_valid && ex_op == OP_HALT;
  assign wr = ex_valid && ex_op != OP_HALT;
  assign ex_val = ex_op == OP_LDI ? DATA_W'(ex_imm) : alu_result;
  assign fwd_a = (wr && ex_rd == rs1 && rs1 != '0) ? ex_val : rf_a;
  assign fwd_b = (wr && ex_rd == rs2 && rs2 != '0) ? ex_val : rf_b;
  assign in_if.instr_ready = state == RUN && !ex_halt;
  assign xfer = in_if.instr_valid && in_if.instr_ready;
  assign alu_ctrl = ex_op;
  assign halted = state == HALTED;
  reg_file u_rf (
    .clk(clk), .rst_n(rst_n), .we(wr), .waddr(ex_rd), .wdata(ex_val),
    .ra1(rs1), .rd1(rf_a), .ra2(rs2), .rd2(rf_b),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );
  // EX register: captures the accepted instruction and its (possibly forwarded) operands
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_op <= OP_ADD;
      ex_rd <= '0;
      ex_imm <= '0;
      alu_a <= '0;
      alu_b <= '0;
    end else begin
      ex_valid <= xfer;
      if (xfer) begin
        ex_op <= op;
        ex_rd <= rd;
        ex_imm <= in_if.instr[IMM_W-1:0];
        alu_a <= fwd_a;
        alu_b <= fwd_b;
      end
    end
  // writeback report: pulse per register write, rd/data hold the last write
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_rd <= '0;
      wb_data <= '0;
    end else begin
      wb_valid <= wr;
      if (wr) begin
        wb_rd <= ex_rd;
        wb_data <= ex_val;
      end
    end
  // run/halt state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= RUN;
    else state <= state_nxt;
  // halt once a HALT reaches EX, leave on resume pulse
  always_comb begin
    state_nxt = state;
    state_nxt = (state == RUN && ex_halt) ? HALTED : (state == HALTED && resume) ? RUN : state;
  end
endmodule

// File: tb/tb_exec_stage.sv
// tb_exec_stage: directed self-checking bench for exec_stage with a behavioural ALU
module tb_exec_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        resume = 1'b0;
  logic [15:0] alu_a, alu_b, alu_result, wb_data, dbg_data;
  logic [2:0]  alu_ctrl, wb_rd;
  logic [2:0]  dbg_addr = 3'd0;
  logic        wb_valid, halted;
  int checks = 0;
  int errors = 0;
  exec_stage_if bus ();
  exec_stage dut (
    .clk(clk), .rst_n(rst_n), .in_if(bus.slave), .resume(resume),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .halted(halted),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );
  always #5 clk = ~clk;
  always_comb begin
    alu_result = 16'h0000;
    case (alu_ctrl)
      3'd0: alu_result = alu_a + alu_b;
      3'd1: alu_result = alu_a - alu_b;
      3'd2: alu_result = alu_a & alu_b;
      3'd3: alu_result = alu_a | alu_b;
      3'd4: alu_result = alu_a ^ alu_b;
      3'd5: alu_result = ~(alu_a | alu_b);
      default: alu_result = 16'h0000;
    endcase
  end
  function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [9:0] imm);
    return {3'b110, rd, imm};
  endfunction
  function automatic logic [15:0] alu(input logic [2:0] op, rd, ra, rb);
    return {op, rd, ra, rb, 4'b0000};
  endfunction
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [15:0] i);
    bus.instr_valid = 1'b1;
    bus.instr = i;
    tick();
  endtask
  task automatic idle();
    bus.instr_valid = 1'b0;
    tick();
  endtask
  task automatic wb(input string tag, input logic [2:0] r, input logic [15:0] d);
    chk({tag, ".wb_valid"}, 16'(wb_valid), 16'h1);
    chk({tag, ".wb_rd"}, 16'(wb_rd), 16'(r));
    chk({tag, ".wb_data"}, wb_data, d);
  endtask
  initial begin
    bus.instr_valid = 1'b0;
    bus.instr = 16'h0000;
    #12 rst_n = 1'b1;
    #1;
    chk("rst.ready", 16'(bus.instr_ready), 16'h1);
    chk("rst.halted", 16'(halted), 16'h0);
    chk("rst.wb_valid", 16'(wb_valid), 16'h0);
    chk("rst.alu_a", alu_a, 16'h0);
    chk("rst.alu_ctrl", 16'(alu_ctrl), 16'h0);
    issue(ldi(3'd1, 10'd5));
    issue(ldi(3'd2, 10'd3));
    wb("t1.r1", 3'd1, 16'd5);
    issue(alu(3'd0, 3'd3, 3'd1, 3'd2));
    wb("t1.r2", 3'd2, 16'd3);
    idle();
    wb("t1.r3", 3'd3, 16'd8);
    dbg_addr = 3'd3;
    #1 chk("t1.dbg_r3", dbg_data, 16'd8);
    issue(ldi(3'd1, 10'h3FF));
    issue(alu(3'd1, 3'd2, 3'd1, 3'd1));
    chk("t2.fwd_a", alu_a, 16'h03FF);
    wb("t2.r1", 3'd1, 16'h03FF);
    issue(alu(3'd5, 3'd3, 3'd2, 3'd0));
    wb("t2.r2", 3'd2, 16'h0000);
    idle();
    wb("t2.r3", 3'd3, 16'hFFFF);
    #1 chk("t2.dbg_r3", dbg_data, 16'hFFFF);
    issue(ldi(3'd1, 10'd1));
    issue(alu(3'd5, 3'd2, 3'd0, 3'd0));
    wb("t3.r1", 3'd1, 16'h0001);
    issue(alu(3'd0, 3'd3, 3'd2, 3'd1));
    wb("t3.r2", 3'd2, 16'hFFFF);
    idle();
    wb("t3.r3", 3'd3, 16'h0000);
    #1 chk("t3.dbg_r3", dbg_data, 16'h0000);
    issue(16'hE000);
    chk("t4.ready_after_halt", 16'(bus.instr_ready), 16'h0);
    chk("t4.halted_at_n", 16'(halted), 16'h0);
    bus.instr = ldi(3'd4, 10'd9);
    tick();
    chk("t4.halted_n1", 16'(halted), 16'h1);
    chk("t4.wb_halt", 16'(wb_valid), 16'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4.ready_held_low", 16'(bus.instr_ready), 16'h0);
    end
    chk("t4.not_accepted", 16'(alu_ctrl), 16'h7);
    dbg_addr = 3'd4;
    #1 chk("t4.dbg_r4_empty", dbg_data, 16'h0000);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("t4.resumed", 16'(halted), 16'h0);
    chk("t4.ready_resumed", 16'(bus.instr_ready), 16'h1);
    tick();
    chk("t4.accepted", 16'(alu_ctrl), 16'h6);
    idle();
    wb("t4.r4", 3'd4, 16'd9);
    issue(ldi(3'd0, 10'd7));
    issue(alu(3'd0, 3'd1, 3'd0, 3'd0));
    wb("t5.r0", 3'd0, 16'd7);
    idle();
    wb("t5.r1", 3'd1, 16'h0000);
    dbg_addr = 3'd0;
    #1 chk("t5.dbg_r0", dbg_data, 16'h0000);
    issue(alu(3'd0, 3'd6, 3'd2, 3'd2));
    rst_n = 1'b0;
    bus.instr_valid = 1'b0;
    #1 chk("t6.wb_in_reset", 16'(wb_valid), 16'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6.wb_after_reset", 16'(wb_valid), 16'h0);
    chk("t6.halted", 16'(halted), 16'h0);
    chk("t6.ready", 16'(bus.instr_ready), 16'h1);
    for (int r = 0; r < 8; r++) begin
      dbg_addr = 3'(r);
      #1 chk($sformatf("t6.dbg_r%0d", r), dbg_data, 16'h0000);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
